// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, hex decode table
// and the all-dark segment/enable patterns.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Active-low {dp,g..a}, indexed by nibble; entry 15 is the leftmost literal.
  localparam logic [15:0][7:0] HEX_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

endpackage

// File: rtl/seven_seg_scanner_hex.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_LUT[i_nibble][6:0];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with guard-band anti-ghosting and
// frame-synchronous display updates fed through a one-deep pending register.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loadValid,
  input  logic [15:0] loadData,
  input  logic [3:0]  dpIn,
  input  logic [3:0]  blankMask,
  output logic        loadReady,
  output logic [7:0]  segments,
  output logic [3:0]  digitEnable,
  output logic        frameDone
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (REFRESH_DIV < GUARD_CYCLES + 2) begin : g_bad_params
    $error("REFRESH_DIV must be at least GUARD_CYCLES+2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_pend_vld;
  disp_t            r_pend;
  disp_t            r_disp;
  logic [7:0]       r_seg;

  logic       w_frame_end;
  logic       w_accept;
  logic [3:0] w_nibble;
  logic       w_dp;
  logic       w_blank;
  logic [6:0] w_seg7;
  logic [3:0] w_dig_en;

  assign w_frame_end = (r_idx == IDX_LAST) && (r_cnt == CNT_LAST);
  assign w_accept    = loadValid && !r_pend_vld && !reset;
  assign w_nibble    = r_disp.data[{r_idx, 2'b00} +: 4];
  assign w_dp        = r_disp.dp[r_idx];
  assign w_blank     = r_disp.blank[r_idx];

  hex_to_seven_seg u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_disp     <= '0;
      r_seg      <= SEG_OFF;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Segments latch once per digit period, well inside the guard band.
      if (r_cnt == '0) begin
        r_seg <= {~w_dp, w_seg7};
      end
      // Accept and transfer are exclusive: acceptance needs an empty pending slot.
      if (w_accept) begin
        r_pend_vld <= 1'b1;
        r_pend     <= {loadData, dpIn, blankMask};
      end else if (w_frame_end && r_pend_vld) begin
        r_disp     <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    w_dig_en = DIG_OFF;
    if (!reset && (r_cnt >= CNT_GUARD) && !w_blank) begin
      w_dig_en[r_idx] = 1'b0;
    end
  end

  assign segments    = r_seg;
  assign digitEnable = w_dig_en;
  assign frameDone   = w_frame_end && !reset;
  assign loadReady   = reset || !r_pend_vld;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a frame-level reference model queues the
// expected outputs per cycle and an independent monitor compares them mid-cycle.
module tb_seven_seg_scanner;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        loadValid = 1'b0;
  logic [15:0] loadData = '0;
  logic [3:0]  dpIn = '0;
  logic [3:0]  blankMask = '0;
  logic        loadReady;
  logic [7:0]  segments;
  logic [3:0]  digitEnable;
  logic        frameDone;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
    .clk         (clk),
    .reset       (reset),
    .loadValid   (loadValid),
    .loadData    (loadData),
    .dpIn        (dpIn),
    .blankMask   (blankMask),
    .loadReady   (loadReady),
    .segments    (segments),
    .digitEnable (digitEnable),
    .frameDone   (frameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] en;
    logic       fd;
    logic       rdy;
    logic       chk_seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference decode, index = hex value
  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state; display values packed as {data, dp, blank}
  int          t = 0;
  bit          prev_rst = 1'b0;
  bit          m_pend = 1'b0;
  int          m_pend_frame = 0;
  logic [23:0] m_pend_val = '0;
  logic [23:0] m_disp = '0;
  logic [7:0]  m_seg_hold = 8'hFF;

  function automatic logic [7:0] digit_seg(input logic [23:0] v, input int d);
    logic [3:0] nib;
    logic [7:0] h;
    nib   = v[8 + d*4 +: 4];
    h     = HEX[nib];
    h[7]  = ~v[4 + d];
    return h;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl);
    exp_t        e;
    logic [23:0] cur;
    int          dg;
    @(posedge clk);
    #1;
    reset = rst; loadValid = v; loadData = d; dpIn = dp; blankMask = bl;
    if (rst) begin
      e.seg = 8'hFF; e.en = 4'hF; e.fd = 1'b0; e.rdy = 1'b1; e.chk_seg = prev_rst;
      prev_rst = 1'b1; t = 0; m_pend = 1'b0; m_disp = '0; m_seg_hold = 8'hFF;
    end else begin
      prev_rst = 1'b0;
      if (m_pend && t == m_pend_frame * FRAME) begin
        m_disp = m_pend_val;
        m_pend = 1'b0;
      end
      cur = m_disp;
      dg  = (t / DIV) % 4;
      e.seg = m_seg_hold;
      e.en  = ((t % DIV) < GUARD || cur[dg]) ? 4'hF : ~(4'b0001 << dg);
      e.fd  = (t % FRAME) == FRAME - 1;
      e.rdy = !m_pend;
      e.chk_seg = 1'b1;
      if (t % DIV == 0) m_seg_hold = digit_seg(cur, dg);
      if (v && !m_pend) begin
        m_pend       = 1'b1;
        m_pend_val   = {d, dp, bl};
        m_pend_frame = t / FRAME + (((t % FRAME) == FRAME - 1) ? 2 : 1);
      end
      t++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
  endtask

  // Monitor: compares every queued expectation against the live outputs mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_seg) check("segments", segments, e.seg);
        check("digitEnable", {4'h0, digitEnable}, {4'h0, e.en});
        check("frameDone", {7'h0, frameDone}, {7'h0, e.fd});
        check("loadReady", {7'h0, loadReady}, {7'h0, e.rdy});
      end
    end
  end

  initial begin
    // Reset and idle scan: C0 on digit 0, guard band then enables
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(40);
    // Mid-frame load, then a back-pressured second load that must be ignored
    step(1'b0, 1'b1, 16'h1A2F, 4'b0100, 4'b0000);
    step(1'b0, 1'b1, 16'h5555, 4'b1111, 4'b0000);
    idle(90);
    // Blanked digit 3
    for (int i = 0; i < 64 && m_pend; i++) idle(1);
    step(1'b0, 1'b1, 16'h8421, 4'b0000, 4'b1000);
    idle(80);
    // Load exactly on the frame-end cycle
    for (int i = 0; i < 100 && !(((t % FRAME) == FRAME - 1) && !m_pend); i++) idle(1);
    step(1'b0, 1'b1, 16'hBEEF, 4'b0011, 4'b0000);
    idle(100);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
    end
    // Reset at digit 2 counter 5 with a load pending
    for (int i = 0; i < 100 && !(((t % FRAME) == 3) && !m_pend); i++) idle(1);
    step(1'b0, 1'b1, 16'h7777, 4'b1111, 4'b0000);
    for (int i = 0; i < 40 && !((t % FRAME) == 2 * DIV + 5); i++) idle(1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(80);
    // Drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
